// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: a small FIFO that sits between the fetch stage and decode.
// Each entry holds one {pc, instr} pair. A flush (branch/jump redirect) drops every entry.
// The head entry is read straight out of storage, with no output register.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and decode is
// ready, the incoming word goes straight through to the output and is not stored.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PCW   = 8,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PCW-1:0]           in_pc,
  input  logic [IW-1:0]            in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PCW-1:0]           out_pc,
  output logic [IW-1:0]            out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately left out of reset; the count and pointers qualify it.
  logic [PCW-1:0] pc_mem_q    [DEPTH];
  logic [IW-1:0]  instr_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stored_valid;
  logic          bypass;
  logic          push;
  logic          pop;

  assign stored_valid = (count_q != '0);
  assign in_ready     = (count_q != FULL_CNT);
  assign count        = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass    = !stored_valid && in_valid && out_ready && !flush;
  assign out_valid = stored_valid || bypass;
  assign out_pc    = bypass ? in_pc    : pc_mem_q[rd_ptr_q];
  assign out_instr = bypass ? in_instr : instr_mem_q[rd_ptr_q];
`else
  assign bypass    = 1'b0;
  assign out_valid = stored_valid;
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];
`endif

  // A full queue refuses the push even when a pop happens in the same cycle.
  // A word that takes the bypass path is never written into storage.
  assign push = in_valid && in_ready && !flush && !bypass;
  assign pop  = stored_valid && out_ready && !flush;

  // Next state for the pointers and count; flush has priority over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; an asynchronous reset drops all entries at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the accepted {pc, instr} pair into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios followed by random traffic.
// A reference FIFO (a queue) is updated on every clock edge.
// A monitor compares the DUT outputs against that reference on each falling edge.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PCW   = 8;
  localparam int IW    = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [PCW-1:0]         in_pc;
  logic [IW-1:0]          in_instr;
  logic                   in_ready;
  logic                   out_valid;
  logic [PCW-1:0]         out_pc;
  logic [IW-1:0]          out_instr;
  logic                   out_ready;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
  } entry_t;

  entry_t exp_q[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .PCW(PCW), .IW(IW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (exp_q.size() == 0) && in_valid && out_ready && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Reference FIFO: flush clears it. Otherwise a pop happens when it holds data and
  // decode is ready, and a push happens when it had room before this edge.
  bit do_pop, do_push;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH) && !bypass_now();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pc, in_instr});
    end
  end

  // Monitor: compare occupancy, handshake signals and the head entry each cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      if (bypass_now()) begin
        check("bypass_valid", 64'(out_valid), 64'(1));
        check("bypass_pc", 64'(out_pc), 64'(in_pc));
        check("bypass_instr", 64'(out_instr), 64'(in_instr));
      end else begin
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
          check("head_instr", 64'(out_instr), 64'(exp_q[0].instr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [PCW-1:0] pc, input logic [IW-1:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    #20;
    reset = 1'b1;
    step();

    // Fill the queue; the fifth word arrives while it is full and must be dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, PCW'(i * 4), 32'h1000_0000 | 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));

    // Drain the queue and confirm FIFO order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      check("drain_pc", 64'(out_pc), 64'(i * 4));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("drained_count", 64'(count), 64'(0));
    check("drained_valid", 64'(out_valid), 64'(0));

    // Two entries, then six cycles of simultaneous push and pop; the pointers wrap.
    drive(1'b1, 8'h18, 32'h18, 1'b0, 1'b0); step();
    drive(1'b1, 8'h1C, 32'h1C, 1'b0, 1'b0); step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, PCW'(8'h20 + 4 * i), 32'(8'h20 + 4 * i), 1'b1, 1'b0);
      check("pp_pc", 64'(out_pc), 64'(8'h18 + 4 * i));
      step();
      check("pp_count", 64'(count), 64'(2));
    end

    // Three entries, then a flush arrives together with a push; the pushed word must be lost.
    drive(1'b1, 8'h38, 32'h38, 1'b0, 1'b0); step();
    check("pre_flush_count", 64'(count), 64'(3));
    drive(1'b1, 8'h40, 32'h40, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    step();
    check("flush_absent", 64'(out_valid), 64'(0));

    // Assert reset between clock edges; the queue must empty before the next edge.
    drive(1'b1, 8'h50, 32'h50, 1'b0, 1'b0); step();
    drive(1'b1, 8'h54, 32'h54, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_reset_count", 64'(count), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_count", 64'(count), 64'(0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    step();

    // Latency from an empty queue: same cycle with bypass, otherwise one cycle later.
    drive(1'b1, 8'h24, 32'h0050_0093, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("lat_valid_now", 64'(out_valid), 64'(1));
    check("lat_pc_now", 64'(out_pc), 64'(8'h24));
    check("lat_instr_now", 64'(out_instr), 64'(32'h0050_0093));
    check("lat_count_now", 64'(count), 64'(0));
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("lat_count_after", 64'(count), 64'(0));
`else
    check("lat_valid_now", 64'(out_valid), 64'(0));
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("lat_valid_next", 64'(out_valid), 64'(1));
    check("lat_pc_next", 64'(out_pc), 64'(8'h24));
    check("lat_instr_next", 64'(out_instr), 64'(32'h0050_0093));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("lat_drained", 64'(count), 64'(0));
`endif

    // Random traffic in three phases: filling, balanced and draining.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        drive(($urandom % 4) < 3 - ph, PCW'($urandom), IW'($urandom),
              ($urandom % 4) < ph + 1, ($urandom % 25) == 0);
        step();
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 2) step();
    check("final_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
